// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT butterfly datapath.
// Imported by the scheduler and its address generator.
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } bfly_state_t;

  localparam int NTT_LOGN = 8;

  localparam logic PE_SUM  = 1'b0;
  localparam logic PE_DIFF = 1'b1;

endpackage

// File: rtl/ntt_bfly_addr_gen.sv
// Combinational butterfly address / twiddle index generator.
// Half-span is always a power of two, so div/mod reduce to shift/mask.
module ntt_bfly_addr_gen
  import ntt_pkg::*;
#(
  parameter  int LOGN = NTT_LOGN,
  localparam int SW   = $clog2(LOGN)
) (
  input  logic [SW-1:0]   stage,
  input  logic [LOGN-2:0] j,
  input  logic            inv,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [LOGN-1:0] tf_addr
);

  logic [LOGN-1:0] jx;
  logic [LOGN-1:0] rs;
  logic [LOGN-1:0] lg;
  logic [LOGN-1:0] len;
  logic [LOGN-1:0] g;
  logic [LOGN-1:0] k;
  logic [LOGN-1:0] tfb;

  always_comb begin
    jx  = {1'b0, j};
    rs  = LOGN'(LOGN - 1) - LOGN'(stage);
    lg  = inv ? LOGN'(stage) : rs;
    len = LOGN'(1) << lg;
    g   = jx >> lg;
    k   = jx & (len - LOGN'(1));
    addr_a = (g << (lg + LOGN'(1))) | k;
    addr_b = addr_a + len;
    // Forward walks twiddle blocks upward, inverse walks them downward
    tfb = inv ? (LOGN'(1) << rs) : (LOGN'(1) << stage);
    tf_addr = tfb + g;
  end

endmodule

// File: rtl/ntt_bfly_sched.sv
// NTT/INTT butterfly issue scheduler: two PE ops per butterfly,
// stage-by-stage, with a writeback drain wait between stages.
module ntt_bfly_sched
  import ntt_pkg::*;
#(
  parameter  int LOGN = NTT_LOGN,
  localparam int SW   = $clog2(LOGN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            inv_mode,
  input  logic            drain_idle,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [LOGN-1:0] tf_addr,
  output logic            pe_inv,
  output logic            pe_sub,
  output logic            tf_one,
  output logic [SW-1:0]   stage,
  output logic            busy,
  output logic            done
);

  localparam logic [LOGN-2:0] JMAX  = '1;
  localparam logic [SW-1:0]   SLAST = SW'(LOGN - 1);

  bfly_state_t     state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [LOGN-2:0] j_q, j_d;
  logic            phase_q, phase_d;
  logic            inv_q, inv_d;
  logic [LOGN-1:0] a_q, b_q, tf_q;
  logic [LOGN-1:0] a_n, b_n, tf_n;

  // Fed with next-state so the registered fields line up with state_q
  ntt_bfly_addr_gen #(.LOGN(LOGN)) u_gen (
    .stage   (stage_d),
    .j       (j_d),
    .inv     (inv_d),
    .addr_a  (a_n),
    .addr_b  (b_n),
    .tf_addr (tf_n)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    phase_d = phase_q;
    inv_d   = inv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          inv_d   = inv_mode;
          stage_d = '0;
          j_d     = '0;
          phase_d = PE_SUM;
        end
      end
      ST_ISSUE: begin
        if (out_ready) begin
          if (phase_q == PE_SUM) begin
            phase_d = PE_DIFF;
          end else begin
            phase_d = PE_SUM;
            j_d     = j_q + 1'b1;
            if (j_q == JMAX) state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_idle) begin
          if (stage_q == SLAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + 1'b1;
            j_d     = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      j_q     <= '0;
      phase_q <= PE_SUM;
      inv_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tf_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      j_q     <= j_d;
      phase_q <= phase_d;
      inv_q   <= inv_d;
      a_q     <= a_n;
      b_q     <= b_n;
      tf_q    <= tf_n;
    end
  end

  assign out_valid = (state_q == ST_ISSUE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign stage     = stage_q;
  assign addr_a    = a_q;
  assign addr_b    = b_q;
  assign tf_addr   = tf_q;
  assign pe_inv    = inv_q;
  assign pe_sub    = phase_q;
  assign tf_one    = inv_q & ~phase_q;

endmodule

// File: tb/tb_ntt_bfly_sched.sv
// Self-checking bench for ntt_bfly_sched (LOGN=3 and LOGN=2 instances)
// against an arithmetic reference of the butterfly walk.
module tb_ntt_bfly_sched;

  localparam int L3 = 3;
  localparam int N3 = 8;
  localparam int L2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic inv_mode = 1'b0;
  logic drain_idle = 1'b1;
  logic out_ready = 1'b1;
  logic out_valid, pe_inv, pe_sub, tf_one, busy, done;
  logic [2:0] addr_a, addr_b, tf_addr;
  logic [1:0] stage;

  logic start2 = 1'b0;
  logic inv2 = 1'b0;
  logic v2, pinv2, psub2, one2, busy2, done2;
  logic [1:0] a2, b2, tf2;
  logic [0:0] st2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ntt_bfly_sched #(.LOGN(L3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .inv_mode(inv_mode),
    .drain_idle(drain_idle), .out_ready(out_ready),
    .out_valid(out_valid), .addr_a(addr_a), .addr_b(addr_b),
    .tf_addr(tf_addr), .pe_inv(pe_inv), .pe_sub(pe_sub),
    .tf_one(tf_one), .stage(stage), .busy(busy), .done(done)
  );

  ntt_bfly_sched #(.LOGN(L2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .inv_mode(inv2),
    .drain_idle(1'b1), .out_ready(1'b1),
    .out_valid(v2), .addr_a(a2), .addr_b(b2),
    .tf_addr(tf2), .pe_inv(pinv2), .pe_sub(psub2),
    .tf_one(one2), .stage(st2), .busy(busy2), .done(done2)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_op(int logn, bit inv, int s,
                                         int j, bit sub);
    int n, len, g, k, a, tf;
    n   = 1 << logn;
    len = inv ? (1 << s) : (n >> (s + 1));
    g   = j / len;
    k   = j % len;
    a   = 2 * len * g + k;
    tf  = inv ? (1 << (logn - 1 - s)) + g : (1 << s) + g;
    return {12'd0, 4'(s), 4'(a), 4'(a + len), 4'(tf),
            1'b0, sub, inv, inv & ~sub};
  endfunction

  function automatic logic [31:0] obs3();
    return {12'd0, 4'(stage), 4'(addr_a), 4'(addr_b), 4'(tf_addr),
            1'b0, pe_sub, pe_inv, tf_one};
  endfunction

  function automatic logic [31:0] mk(int s, int a, int b, int tf,
                                     bit sub, bit inv, bit one);
    return {12'd0, 4'(s), 4'(a), 4'(b), 4'(tf), 1'b0, sub, inv, one};
  endfunction

  // Hand-derived operations from the worked examples
  task automatic spot(bit inv, int idx);
    if (!inv) begin
      if (idx == 0)  chk("spot_f_s0j0_sum", obs3(), mk(0, 0, 4, 1, 0, 0, 0));
      if (idx == 1)  chk("spot_f_s0j0_dif", obs3(), mk(0, 0, 4, 1, 1, 0, 0));
      if (idx == 8)  chk("spot_f_s1j0",     obs3(), mk(1, 0, 2, 2, 0, 0, 0));
      if (idx == 12) chk("spot_f_s1j2",     obs3(), mk(1, 4, 6, 3, 0, 0, 0));
      if (idx == 22) chk("spot_f_s2j3",     obs3(), mk(2, 6, 7, 7, 0, 0, 0));
    end else begin
      if (idx == 2)  chk("spot_i_s0j1_sum", obs3(), mk(0, 2, 3, 5, 0, 1, 1));
      if (idx == 3)  chk("spot_i_s0j1_dif", obs3(), mk(0, 2, 3, 5, 1, 1, 0));
      if (idx == 18) chk("spot_i_s2j1",     obs3(), mk(2, 1, 5, 1, 0, 1, 1));
    end
  endtask

  // mode 0: ready/drain high; 1: random ready/drain + start held;
  // 2: ready low 3 cycles mid-stage, drain low 5 cycles after stage 0
  task automatic run(bit inv, int mode);
    logic [31:0] exp_q[$];
    int idx, total, busy_cyc, dones, dcnt, rcnt, cyc;
    bit in_drain, done_next, finished, rdy, drn;
    idx = 0; total = L3 * N3; busy_cyc = 0; dones = 0;
    dcnt = 0; rcnt = 0; cyc = 0;
    in_drain = 0; done_next = 0; finished = 0;
    for (int s = 0; s < L3; s++)
      for (int j = 0; j < N3 / 2; j++)
        for (int sb = 0; sb < 2; sb++)
          exp_q.push_back(ref_op(L3, inv, s, j, sb[0]));
    inv_mode = inv;
    out_ready = 1'b1;
    drain_idle = 1'b1;
    start = 1'b1;
    step();
    start = (mode == 1);
    inv_mode = ~inv;
    while (!finished && cyc < 2000) begin
      cyc++;
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) dones++;
      chk("valid", out_valid, !(in_drain || done_next));
      chk("busy", busy, 1);
      chk("done", done, done_next);
      if (out_valid === 1'b1 && idx < total) begin
        chk($sformatf("op%0d", idx), obs3(), exp_q[idx]);
        spot(inv, idx);
      end
      if (done_next) begin
        finished = 1;
      end else begin
        rdy = 1'b1;
        drn = 1'b1;
        if (mode == 1) begin
          rdy = ($urandom_range(0, 3) != 0);
          drn = ($urandom_range(0, 1) != 0);
        end else if (mode == 2) begin
          if (!in_drain && idx == 3 && rcnt < 3) begin
            rdy = 1'b0;
            rcnt++;
          end
          if (in_drain && idx == N3 && dcnt < 5) begin
            drn = 1'b0;
            dcnt++;
          end
        end
        out_ready = rdy;
        drain_idle = drn;
        if (!in_drain && rdy) begin
          idx++;
          if (idx % N3 == 0) in_drain = 1;
        end else if (in_drain && drn) begin
          in_drain = 0;
          if (idx == total) done_next = 1;
        end
        step();
      end
    end
    chk("finished", finished, 1);
    chk("done_pulses", dones, 1);
    chk("op_count", idx, total);
    if (mode == 0) chk("busy_cycles", busy_cyc, L3 * (N3 + 1) + 1);
    if (mode == 2) chk("stall_cycles", rcnt + dcnt, 8);
    step();
    start = 1'b0;
    chk("idle_after", busy, 0);
    chk("valid_after", out_valid, 0);
  endtask

  task automatic run_l2(bit inv);
    int ops, cyc, s, j, sb;
    bit seen[4];
    bit got_done;
    ops = 0; cyc = 0; got_done = 0;
    inv2 = inv;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    while (!got_done && cyc < 60) begin
      cyc++;
      if (done2 === 1'b1) got_done = 1;
      if (v2 === 1'b1) begin
        s = ops / 4;
        j = (ops % 4) / 2;
        sb = ops % 2;
        if (ops % 4 == 0)
          for (int i = 0; i < 4; i++) seen[i] = 0;
        chk($sformatf("l2_op%0d", ops),
            {12'd0, 4'(st2), 4'(a2), 4'(b2), 4'(tf2),
             1'b0, psub2, pinv2, one2},
            ref_op(L2, inv, s, j, sb[0]));
        if (sb == 0 && !$isunknown({a2, b2})) begin
          chk("l2_distinct", seen[a2] | seen[b2] | (a2 == b2), 0);
          seen[a2] = 1;
          seen[b2] = 1;
        end
        ops++;
      end
      step();
    end
    chk("l2_done", got_done, 1);
    chk("l2_ops", ops, 8);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_fields", {stage, addr_a, addr_b, tf_addr,
                       pe_sub, pe_inv, tf_one}, 0);
    chk("rst_ctl", {out_valid, busy, done}, 0);
    rst_n = 1'b1;
    step();

    run(1'b0, 0);
    run(1'b1, 0);
    run(1'b0, 2);
    run(1'b1, 2);
    run(1'b1, 1);
    run(1'b0, 1);

    inv_mode = 1'b1;
    out_ready = 1'b1;
    drain_idle = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (N3 + 1 + 3) step();
    chk("pre_rst_stage", stage, 1);
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    step();
    chk("midrst_fields", {stage, addr_a, addr_b, tf_addr,
                          pe_sub, pe_inv, tf_one}, 0);
    chk("midrst_ctl", {out_valid, busy, done}, 0);
    rst_n = 1'b1;
    inv_mode = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_op", obs3(), ref_op(L3, 0, 0, 0, 0));
    chk("restart_valid", out_valid, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    run_l2(1'b0);
    run_l2(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_bfly_sched.md
# ntt_bfly_sched

Butterfly issue scheduler that sits directly upstream of the NTT/INTT processing-element cell. It walks every stage and butterfly of an N-point in-place transform. For each butterfly it emits two PE operations, with controls `sub=0` and then `sub=1`. Each operation carries a coefficient-RAM address pair, a twiddle-ROM address and the PE mode controls `inv` and `tf_one`, under a valid/ready handshake. Between stages it waits for the downstream writeback to drain, so stage s+1 never reads data that has not yet been written.

## Interface
- `LOGN`, default 8: log2 of the transform length; N = 2^LOGN, valid range 2..12.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: synchronous, active-low reset.
- `start`  input  1: begin a transform; sampled only in IDLE.
- `inv_mode`  input  1: 0 = forward NTT (Cooley-Tukey), 1 = inverse (Gentleman-Sande); latched at start.
- `drain_idle`  input  1: high when the downstream PE/writeback pipeline holds no outstanding results.
- `out_ready`  input  1: downstream accepts the current operation.
- `out_valid`  output  1: the operation fields are valid.
- `addr_a`  output  LOGN: coefficient address of operand a.
- `addr_b`  output  LOGN: coefficient address of operand b.
- `tf_addr`  output  LOGN: twiddle-ROM index; the table bank is selected by `pe_inv`.
- `pe_inv`  output  1: latched `inv_mode`.
- `pe_sub`  output  1: 0 = sum output, 1 = difference output.
- `tf_one`  output  1: forces the twiddle to 1. High only for inverse-mode sum operations.
- `stage`  output  clog2(LOGN): current stage index.
- `busy`  output  1: transform in progress.
- `done`  output  1: one-cycle pulse at completion.

## Operation
- States are IDLE, ISSUE, DRAIN and DONE.
- IDLE → ISSUE when `start` is high. On entry, latch `inv_mode` and clear `stage`, butterfly index `j` (LOGN-1 bits) and `phase`.
- ISSUE: `out_valid`=1. On each cycle with `out_valid && out_ready`:
  - If `phase` is 0, toggle it to 1.
  - Otherwise clear `phase` and increment `j`.
  - After the handshake with `j` = N/2-1 and `phase`=1, go to DRAIN.
- DRAIN: `out_valid`=0. When `drain_idle` is sampled high:
  - If `stage` = LOGN-1, go to DONE.
  - Otherwise increment `stage`, clear `j`, and go to ISSUE.
- DONE: `done`=1 for one cycle, then IDLE.
- Address generation for stage s:
  - Half-span: len = N >> (s+1) in forward mode, len = 1 << s in inverse mode.
  - g = j / len, k = j mod len.
  - `addr_a` = 2·len·g + k, `addr_b` = `addr_a` + len.
- Twiddle index:
  - Forward: `tf_addr` = (1<<s) + g.
  - Inverse: `tf_addr` = (1<<(LOGN-1-s)) + g.
  - All index arithmetic is unsigned and truncated to LOGN bits; no overflow occurs within the valid range.
- `pe_sub` = `phase`; `tf_one` = `pe_inv` & ~`phase`.
- Each stage issues exactly N operations; a full transform issues LOGN·N operations.
- `start` is ignored outside IDLE. `start` coinciding with DONE is ignored.
- `rst_n` low at any time forces IDLE on the next edge and clears all counters, abandoning any transform in progress.

## Timing
- Reset values: `out_valid`=0, `busy`=0, `done`=0, `stage`=0, `addr_a`=0, `addr_b`=0, `tf_addr`=0, `pe_sub`=0, `pe_inv`=0, `tf_one`=0.
- Start latency: `start` sampled in IDLE at edge t gives `out_valid`=1 from cycle t+1.
- All operation fields are registered or derived from registered state only.
- While `out_valid && !out_ready`, every field holds stable.
- Throughput is one operation per cycle while `out_ready` is held high.
- DRAIN lasts at least one cycle, even if `drain_idle` is already high. The first issue of the next stage appears one cycle after `drain_idle` is sampled high.
- `busy` is high from the cycle after start through the DONE cycle inclusive.
- `done` coincides with the last cycle of `busy`.
- Minimum transform length with `out_ready` and `drain_idle` tied high: LOGN·(N+1)+1 cycles of `busy`.

## Structure
- Shared package `ntt_pkg` holds:
  - the state enum `bfly_state_t` (IDLE/ISSUE/DRAIN/DONE);
  - the `LOGN` default;
  - the `PE_SUM`/`PE_DIFF` constants.
- Sub-module `ntt_bfly_addr_gen` is purely combinational:
  - inputs: `stage`, `j`, `inv`;
  - outputs: `addr_a`, `addr_b`, `tf_addr`.
- The scheduler registers the sub-module outputs.

## Test plan
- Forward mode, LOGN=3, ready/drain held high:
  - stage 0, j=0 → a=0, b=4, tf=1, two ops with sub 0 then 1, `tf_one`=0;
  - stage 1, j=2 → a=4, b=6, tf=3;
  - stage 2, j=3 → a=6, b=7, tf=7;
  - 24 ops total, one `done` pulse, 28 busy cycles.
- Inverse mode, LOGN=3:
  - stage 0, j=1 → a=2, b=3, tf=5, `tf_one`=1 on the sum op and 0 on the diff op;
  - stage 2, j=1 → a=1, b=5, tf=1.
- Back-pressure: drop `out_ready` for 3 cycles mid-stage → fields stable; no operation is skipped or duplicated (scoreboard against the reference address sequence).
- Drain stall: hold `drain_idle` low for 5 cycles after stage 0 → `out_valid`=0 throughout; stage 1's first op (a=0, b=2, tf=2) appears one cycle after `drain_idle` rises.
- Start while busy is ignored. Reset asserted mid-stage-1 → next cycle shows IDLE with all outputs at reset values; a new start then begins again at stage 0, j=0.
- LOGN=2 boundary: 8 ops total; every address pair is distinct within each stage.
